// File: rtl/ctrl_seq_pkg.sv
// rtl/ctrl_seq_pkg.sv - shared state encoding and instruction layout helpers for ctrl_seq
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MAC   = 3'd2,
        S_STORE = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int instr_width(input int len_w, input int da_w, input int rf_w);
        return 1 + len_w + 2 * da_w + rf_w;
    endfunction

    // Instruction fields from LSB upward: rd, coef_base, data_base, len, last
    function automatic int coef_lsb(input int rf_w);
        return rf_w;
    endfunction

    function automatic int data_lsb(input int da_w, input int rf_w);
        return rf_w + da_w;
    endfunction

    function automatic int len_lsb(input int da_w, input int rf_w);
        return rf_w + 2 * da_w;
    endfunction

    function automatic int last_bit(input int len_w, input int da_w, input int rf_w);
        return rf_w + 2 * da_w + len_w;
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// rtl/ctrl_seq_if.sv - frame handshake, result handshake and datapath strobe bundle
interface ctrl_seq_if #(
    parameter int CH_W        = 1,
    parameter int DATA_ADDR_W = 4,
    parameter int RF_ADDR_W   = 3
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        out_valid;
    logic                        out_ready;
    logic [CH_W-1:0]             out_ch;
    logic                        data_en;
    logic [CH_W+DATA_ADDR_W-1:0] data_addr;
    logic [DATA_ADDR_W-1:0]      coef_addr;
    logic                        mac_first;
    logic                        mac_last;
    logic                        rf_we;
    logic [RF_ADDR_W-1:0]        ard;

    modport master (
        input  in_valid, out_ready,
        output in_ready, out_valid, out_ch, data_en, data_addr, coef_addr,
               mac_first, mac_last, rf_we, ard
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, out_valid, out_ch, data_en, data_addr, coef_addr,
               mac_first, mac_last, rf_we, ard
    );
endinterface

// File: rtl/ctrl_seq_istore.sv
// rtl/ctrl_seq_istore.sv - instruction store: synchronous write, registered read
module ctrl_seq_istore #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Contents survive reset; only the read register is cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - programmable multi-channel MAC sequencer for the rate converter datapath
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int  NUM_CH      = 2,
    parameter int  INSTR_DEPTH = 16,
    parameter int  LEN_W       = 4,
    parameter int  DATA_ADDR_W = 4,
    parameter int  RF_ADDR_W   = 3,
    localparam int CH_W        = ch_width(NUM_CH),
    localparam int PC_W        = $clog2(INSTR_DEPTH),
    localparam int INSTR_W     = instr_width(LEN_W, DATA_ADDR_W, RF_ADDR_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               prog,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic               busy,
    output logic [PC_W-1:0]    pc,
    output logic               err,
    ctrl_seq_if.master         bus
);
    localparam int COEF_LSB = coef_lsb(RF_ADDR_W);
    localparam int DATA_LSB = data_lsb(DATA_ADDR_W, RF_ADDR_W);
    localparam int LEN_LSB  = len_lsb(DATA_ADDR_W, RF_ADDR_W);
    localparam int LAST_BIT = last_bit(LEN_W, DATA_ADDR_W, RF_ADDR_W);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic             err_q, err_d;

    logic [INSTR_W-1:0]     instr;
    logic                   istore_we;
    logic                   istore_re;
    logic                   instr_last;
    logic [LEN_W-1:0]       instr_len;
    logic [DATA_ADDR_W-1:0] instr_dbase;
    logic [DATA_ADDR_W-1:0] instr_cbase;
    logic [RF_ADDR_W-1:0]   instr_rd;
    logic [DATA_ADDR_W-1:0] k_ext;
    logic [DATA_ADDR_W-1:0] data_off;
    logic [DATA_ADDR_W-1:0] coef_off;
    logic                   tap_last;
    logic                   in_mac;
    logic                   in_store;
    logic                   in_out;
    logic                   data_en;

    assign istore_we = prog & prog_we;
    assign istore_re = en & ~prog & (state_q == S_FETCH);

    ctrl_seq_istore #(
        .DEPTH (INSTR_DEPTH),
        .WIDTH (INSTR_W)
    ) u_istore (
        .clk   (clk),
        .rst   (rst),
        .we    (istore_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (istore_re),
        .raddr (pc_q),
        .rdata (instr)
    );

    assign instr_last  = instr[LAST_BIT];
    assign instr_len   = instr[LEN_LSB +: LEN_W];
    assign instr_dbase = instr[DATA_LSB +: DATA_ADDR_W];
    assign instr_cbase = instr[COEF_LSB +: DATA_ADDR_W];
    assign instr_rd    = instr[0 +: RF_ADDR_W];

    // Address adders wrap modulo the per-channel window
    assign k_ext    = DATA_ADDR_W'(k_q);
    assign data_off = instr_dbase + k_ext;
    assign coef_off = instr_cbase + k_ext;
    assign tap_last = (k_q == instr_len);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ch_d    = ch_q;
        k_d     = k_q;
        err_d   = err_q;
        if (prog) begin
            state_d = S_IDLE;
            pc_d    = '0;
            ch_d    = '0;
            k_d     = '0;
            err_d   = 1'b0;
        end else if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        pc_d    = '0;
                        ch_d    = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    k_d     = '0;
                    state_d = S_MAC;
                end
                S_MAC: begin
                    if (tap_last) begin
                        state_d = S_STORE;
                    end else begin
                        k_d = k_q + LEN_W'(1);
                    end
                end
                S_STORE: begin
                    if (instr_last) begin
                        state_d = S_OUT;
                    end else if (pc_q == PC_W'(INSTR_DEPTH - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
                            state_d = S_IDLE;
                        end else begin
                            ch_d    = ch_q + CH_W'(1);
                            pc_d    = '0;
                            state_d = S_FETCH;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ch_q    <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ch_q    <= ch_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    assign in_mac   = (state_q == S_MAC);
    assign in_store = (state_q == S_STORE);
    assign in_out   = (state_q == S_OUT);
    assign data_en  = en & in_mac;

    // in_ready is held low while reset is asserted so every output reads 0 in reset
    assign bus.in_ready  = rst & en & ~prog & (state_q == S_IDLE);
    assign bus.data_en   = data_en;
    assign bus.data_addr = in_mac ? {ch_q, data_off} : '0;
    assign bus.coef_addr = in_mac ? coef_off : '0;
    assign bus.mac_first = data_en & (k_q == '0);
    assign bus.mac_last  = data_en & tap_last;
    assign bus.rf_we     = en & in_store;
    assign bus.ard       = in_store ? instr_rd : '0;
    assign bus.out_valid = in_out;
    assign bus.out_ch    = in_out ? ch_q : '0;

    assign busy = (state_q != S_IDLE);
    assign pc   = pc_q;
    assign err  = err_q;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - randomized and directed bench for ctrl_seq against a step-queue model
module tb_ctrl_seq;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;
    localparam int K_FETCH = 0;
    localparam int K_MAC   = 1;
    localparam int K_STORE = 2;
    localparam int K_OUT   = 3;

    typedef struct {
        int kind;
        int pc;
        int ch;
        int da;
        int ca;
        bit is_first;
        bit is_last;
        int rd;
        bit errf;
    } step_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        prog;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic        busy;
    logic [3:0]  pc;
    logic        err;

    ctrl_seq_if #(.CH_W(1), .DATA_ADDR_W(4), .RF_ADDR_W(3)) bus ();

    ctrl_seq #(
        .NUM_CH      (NUM_CH),
        .INSTR_DEPTH (DEPTH),
        .LEN_W       (4),
        .DATA_ADDR_W (4),
        .RF_ADDR_W   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .prog      (prog),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .busy      (busy),
        .pc        (pc),
        .err       (err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] shadow [DEPTH];
    step_t q[$];
    int m_pc = 0;
    bit m_err = 0;
    bit prev_ov = 0;
    int busy_total = 0;
    int rfwe_total = 0;
    int first_total = 0;
    int last_total = 0;
    int dlog[$];
    int clog[$];
    int alog[$];
    int plog[$];
    int ovlog[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string nm, input int got[$], input int base, input int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got.size()) chk(nm, got[base + i], exp[i]);
            else chk(nm, got.size(), base + exp.size());
        end
        chk({nm, "_len"}, got.size() - base, exp.size());
    endtask

    function automatic logic [15:0] mk(input int lst, input int l, input int db, input int cb, input int rd);
        logic [15:0] r;
        r = {lst[0], l[3:0], db[3:0], cb[3:0], rd[2:0]};
        return r;
    endfunction

    // Expand one accepted frame into the ordered list of enabled cycles it must take
    task automatic build_frame();
        step_t s;
        logic [15:0] ins;
        int p;
        int l;
        bit done;
        for (int c = 0; c < NUM_CH; c++) begin
            p = 0;
            done = 0;
            while (!done) begin
                ins = shadow[p];
                l = int'(ins[14:11]);
                s = '{K_FETCH, p, c, 0, 0, 0, 0, 0, 0};
                q.push_back(s);
                for (int kk = 0; kk <= l; kk++) begin
                    s = '{K_MAC, p, c, (int'(ins[10:7]) + kk) % 16, (int'(ins[6:3]) + kk) % 16,
                          kk == 0, kk == l, 0, 0};
                    q.push_back(s);
                end
                s = '{K_STORE, p, c, 0, 0, 0, 0, int'(ins[2:0]), !ins[15] && p == DEPTH - 1};
                q.push_back(s);
                if (ins[15] || p == DEPTH - 1) done = 1;
                else p++;
            end
            s = '{K_OUT, p, c, 0, 0, 0, 0, 0, 0};
            q.push_back(s);
        end
    endtask

    task automatic mon();
        step_t h;
        int e_ir, e_busy, e_pc, e_de, e_da, e_ca, e_mf, e_ml, e_we, e_ard, e_ov, e_och;
        if (!rst) begin
            chk("rst_strobes", int'({bus.in_ready, bus.out_valid, bus.data_en, bus.mac_first,
                                     bus.mac_last, bus.rf_we, busy, err}), 0);
            chk("rst_values", int'({bus.data_addr, bus.coef_addr, bus.ard, bus.out_ch, pc}), 0);
            q.delete();
            m_pc = 0;
            m_err = 0;
            prev_ov = 0;
            return;
        end
        e_ir = 0; e_busy = 0; e_pc = m_pc; e_de = 0; e_da = 0; e_ca = 0;
        e_mf = 0; e_ml = 0; e_we = 0; e_ard = 0; e_ov = 0; e_och = 0;
        if (q.size() == 0) begin
            e_ir = int'(en & ~prog);
        end else begin
            h = q[0];
            e_busy = 1;
            e_pc = h.pc;
            case (h.kind)
                K_MAC: begin
                    e_de = int'(en);
                    e_da = h.ch * 16 + h.da;
                    e_ca = h.ca;
                    e_mf = int'(en && h.is_first);
                    e_ml = int'(en && h.is_last);
                end
                K_STORE: begin
                    e_we = int'(en);
                    e_ard = h.rd;
                end
                K_OUT: begin
                    e_ov = 1;
                    e_och = h.ch;
                end
                default: ;
            endcase
        end
        chk("in_ready", int'(bus.in_ready), e_ir);
        chk("busy", int'(busy), e_busy);
        chk("pc", int'(pc), e_pc);
        chk("err", int'(err), int'(m_err));
        chk("data_en", int'(bus.data_en), e_de);
        chk("data_addr", int'(bus.data_addr), e_da);
        chk("coef_addr", int'(bus.coef_addr), e_ca);
        chk("mac_first", int'(bus.mac_first), e_mf);
        chk("mac_last", int'(bus.mac_last), e_ml);
        chk("rf_we", int'(bus.rf_we), e_we);
        chk("ard", int'(bus.ard), e_ard);
        chk("out_valid", int'(bus.out_valid), e_ov);
        chk("out_ch", int'(bus.out_ch), e_och);

        if (busy) busy_total++;
        if (bus.data_en) begin
            dlog.push_back(int'(bus.data_addr));
            clog.push_back(int'(bus.coef_addr));
        end
        if (bus.mac_first) first_total++;
        if (bus.mac_last) last_total++;
        if (bus.rf_we) begin
            rfwe_total++;
            alog.push_back(int'(bus.ard));
            plog.push_back(int'(pc));
        end
        if (bus.out_valid && !prev_ov) ovlog.push_back(busy_total);
        prev_ov = bus.out_valid;

        if (prog) begin
            q.delete();
            m_err = 0;
            m_pc = 0;
        end else if (en) begin
            if (q.size() == 0) begin
                if (bus.in_valid) build_frame();
            end else begin
                h = q[0];
                if (h.kind != K_OUT || bus.out_ready) begin
                    void'(q.pop_front());
                    m_pc = h.pc;
                    if (h.errf) m_err = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        prog = 1'b1;
        prog_we = 1'b1;
        prog_addr = a[3:0];
        prog_data = d;
        shadow[a] = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic prog_done();
        prog = 1'b0;
        step();
    endtask

    task automatic start_frame();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_out(input int budget);
        int n;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            step();
            n++;
        end
        if (!bus.out_valid) chk("out_timeout", int'(bus.out_valid), 1);
    endtask

    initial begin
        int e[$];
        int b0, db0, cb0, ab0, pb0, ob0, fb0, lb0, rb0;
        rst = 1'b1; en = 1'b1; prog = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        fork
            forever begin
                @(negedge clk);
                mon();
            end
        join_none
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_in_ready", int'(bus.in_ready), 0);
        rst = 1'b1;
        step();
        chk("post_reset_in_ready", int'(bus.in_ready), 1);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_pc", int'(pc), 0);

        // Single instruction, both channels, out_ready tied high
        wr(0, mk(1, 3, 2, 5, 4));
        prog_done();
        b0 = busy_total; db0 = dlog.size(); cb0 = clog.size(); ab0 = alog.size();
        ob0 = ovlog.size(); fb0 = first_total; lb0 = last_total; rb0 = rfwe_total;
        start_frame();
        wait_idle(200);
        chk("t1_busy_cycles", busy_total - b0, 14);
        chk("t1_rf_we", rfwe_total - rb0, 2);
        chk("t1_mac_first", first_total - fb0, 2);
        chk("t1_mac_last", last_total - lb0, 2);
        e = '{2, 3, 4, 5, 18, 19, 20, 21};
        chk_seq("t1_data_addr", dlog, db0, e);
        e = '{5, 6, 7, 8, 5, 6, 7, 8};
        chk_seq("t1_coef_addr", clog, cb0, e);
        e = '{4, 4};
        chk_seq("t1_ard", alog, ab0, e);
        if (ovlog.size() > ob0) chk("t1_out_latency", ovlog[ob0] - b0, 7);
        else chk("t1_out_seen", ovlog.size(), ob0 + 1);

        // Two instructions, data address wraps inside the channel window
        wr(0, mk(0, 3, 14, 0, 1));
        wr(1, mk(1, 0, 3, 9, 2));
        prog_done();
        b0 = busy_total; db0 = dlog.size(); ab0 = alog.size(); pb0 = plog.size();
        start_frame();
        wait_idle(200);
        chk("t2_busy_cycles", busy_total - b0, 20);
        e = '{14, 15, 0, 1, 3, 30, 31, 16, 17, 19};
        chk_seq("t2_data_addr", dlog, db0, e);
        e = '{1, 2, 1, 2};
        chk_seq("t2_ard", alog, ab0, e);
        e = '{0, 1, 0, 1};
        chk_seq("t2_pc", plog, pb0, e);

        // Result stall
        bus.out_ready = 1'b0;
        start_frame();
        wait_out(100);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_out_valid", int'(bus.out_valid), 1);
            chk("stall_out_ch", int'(bus.out_ch), 0);
            chk("stall_data_en", int'(bus.data_en), 0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("stall_release_out_valid", int'(bus.out_valid), 0);
        chk("stall_release_busy", int'(busy), 1);
        chk("stall_release_pc", int'(pc), 0);
        wait_idle(200);

        // Program without a last flag runs off the end
        for (int i = 0; i < DEPTH; i++) wr(i, mk(0, 0, i, i, i % 8));
        prog_done();
        chk("err_clear_before", int'(err), 0);
        start_frame();
        wait_out(200);
        chk("err_set", int'(err), 1);
        chk("err_pc", int'(pc), 15);
        wait_idle(300);
        chk("err_sticky", int'(err), 1);
        prog = 1'b1;
        step();
        prog = 1'b0;
        chk("err_cleared", int'(err), 0);
        step();

        // Enable freeze mid-MAC, then abort by prog
        wr(0, mk(1, 7, 0, 0, 3));
        prog_done();
        start_frame();
        step();
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en0_data_en", int'(bus.data_en), 0);
            chk("en0_data_addr", int'(bus.data_addr), 1);
            chk("en0_busy", int'(busy), 1);
        end
        en = 1'b1;
        #1;
        chk("en1_data_en", int'(bus.data_en), 1);
        chk("en1_data_addr", int'(bus.data_addr), 1);
        step();
        chk("en1_next_addr", int'(bus.data_addr), 2);
        prog = 1'b1;
        step();
        chk("abort_busy", int'(busy), 0);
        chk("abort_data_en", int'(bus.data_en), 0);
        prog = 1'b0;
        step();

        // Asynchronous reset in the middle of MAC
        start_frame();
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("async_rst_data_en", int'(bus.data_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_data_addr", int'(bus.data_addr), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        chk("async_rst_release_in_ready", int'(bus.in_ready), 1);
        start_frame();
        wait_idle(200);

        // Randomized programs and handshakes against the model
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                wr(a, mk(($urandom_range(2) == 0 && r != 2) ? 1 : 0, $urandom_range(3),
                         $urandom_range(15), $urandom_range(15), $urandom_range(7)));
            end
            prog_done();
            for (int c = 0; c < 700; c++) begin
                en = ($urandom_range(7) != 0);
                bus.in_valid = 1'($urandom_range(1));
                bus.out_ready = 1'($urandom_range(1));
                prog = ($urandom_range(299) == 0);
                step();
            end
            prog = 1'b0;
            en = 1'b1;
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            step();
            wait_idle(3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
